// File: rtl/lc3b_types.sv
// Shared LC-3b cache types plus the flush-engine state encoding and the
// writeback line-address helper.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [3:0]   lc3b_c_offset;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_SCAN  = 2'd1,
    WB_WRITE = 2'd2,
    WB_DONE  = 2'd3
  } lc3b_wb_state;

  // Physical line address: tag, set index, then a zero byte offset.
  function automatic lc3b_word line_address(input lc3b_c_tag tag, input lc3b_c_index index);
    return {tag, index, lc3b_c_offset'(0)};
  endfunction

endpackage

// File: rtl/cache_writeback_control.sv
// Flush-walk sequencer: owns the state machine and the set counter, and
// exports decoded phase flags for the datapath in cache_writeback.
module cache_writeback_control
  import lc3b_types::*;
#(
  parameter int num_sets = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_req,
  input  logic       valid_in,
  input  logic       dirty_in,
  input  logic       pmem_resp,
  output logic       busy,
  output logic       index_en,
  output logic       writing,
  output logic       done,
  output logic       load_line,
  output logic [2:0] idx
);

  localparam lc3b_c_index last_idx = lc3b_c_index'(num_sets - 1);

  lc3b_wb_state state_reg, state_next;
  lc3b_c_index  idx_reg, idx_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= WB_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_line  = 1'b0;
    case (state_reg)
      WB_IDLE: begin
        if (flush_req) begin
          state_next = WB_SCAN;
          idx_next   = '0;
        end
      end
      WB_SCAN: begin
        if (valid_in && dirty_in) begin
          load_line  = 1'b1;
          state_next = WB_WRITE;
        end else if (idx_reg == last_idx) begin
          state_next = WB_DONE;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      WB_WRITE: begin
        // The walk ends on the last set rather than wrapping the counter.
        if (pmem_resp) begin
          if (idx_reg == last_idx) begin
            state_next = WB_DONE;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = WB_SCAN;
          end
        end
      end
      WB_DONE: begin
        state_next = WB_IDLE;
      end
      default: begin
        state_next = WB_IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != WB_IDLE);
  assign index_en = (state_reg == WB_SCAN) || (state_reg == WB_WRITE);
  assign writing  = (state_reg == WB_WRITE);
  assign done     = (state_reg == WB_DONE);
  assign idx      = idx_reg;

endmodule

// File: rtl/cache_writeback.sv
// L1 flush engine: walks every set and writes each valid dirty line back to
// physical memory, clearing its dirty bit on the memory response.
module cache_writeback
  import lc3b_types::*;
#(
  parameter int width    = 128,
  parameter int num_sets = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_req,
  output logic             wb_busy,
  output logic             flush_done,
  output logic [2:0]       array_index,
  input  logic             valid_in,
  input  logic             dirty_in,
  input  logic [8:0]       tag_in,
  input  logic [width-1:0] line_in,
  output logic             dirty_write,
  output logic             pmem_write,
  output logic [15:0]      pmem_address,
  output logic [width-1:0] pmem_wdata,
  input  logic             pmem_resp
);

  logic        busy;
  logic        index_en;
  logic        writing;
  logic        done;
  logic        load_line;
  logic [2:0]  idx;

  lc3b_word         address_reg;
  logic [width-1:0] data_reg;

  cache_writeback_control #(
    .num_sets (num_sets)
  ) u_control (
    .clk       (clk),
    .reset     (reset),
    .flush_req (flush_req),
    .valid_in  (valid_in),
    .dirty_in  (dirty_in),
    .pmem_resp (pmem_resp),
    .busy      (busy),
    .index_en  (index_en),
    .writing   (writing),
    .done      (done),
    .load_line (load_line),
    .idx       (idx)
  );

  // Captured in the SCAN cycle so the request stays stable while the arrays
  // are still being indexed by the same set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_reg <= '0;
      data_reg    <= '0;
    end else if (load_line) begin
      address_reg <= line_address(tag_in, idx);
      data_reg    <= line_in;
    end
  end

  assign wb_busy      = busy;
  assign flush_done   = done;
  assign array_index  = index_en ? idx : 3'd0;
  assign pmem_write   = writing;
  assign pmem_address = address_reg;
  assign pmem_wdata   = data_reg;
  assign dirty_write  = writing & pmem_resp;

endmodule
